// File: rtl/mbe_r4_iter_mult.sv
`default_nettype none
// ============================================================================
//  Module   : mbe_r4_iter_mult
//  Purpose  : Iterative signed N x N multiplier using radix-4 Modified Booth
//             Encoding. One multiplier triplet is recoded per cycle into a
//             digit in {-2,-1,0,+1,+2}; the resulting partial product is
//             added into a 2N-bit accumulator. N/2 cycles per product.
//  Ports    : clk     - rising-edge clock
//             rst_n   - asynchronous active-low reset
//             start   - begin a multiplication (sampled only when idle)
//             a, b    - multiplicand / multiplier, two's complement, N bits
//             busy    - operation in progress
//             done    - one-cycle pulse, product newly updated
//             product - full 2N-bit signed product, held until next done
//  Revision : 1.0 - initial release
// ============================================================================
module mbe_r4_iter_mult #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    // ------------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------------
    generate
        if (((N % 2) != 0) || (N < 4)) begin : g_bad_n
            $error("mbe_r4_iter_mult: N must be even and >= 4");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CW = ((N / 2) > 1) ? $clog2(N / 2) : 1;

    localparam logic [CW-1:0]  c_last = CW'((N / 2) - 1);
    localparam logic [2*N-1:0] c_one  = {{(2*N-1){1'b0}}, 1'b1};

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_run  = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]     r_state;
    logic [2*N-1:0] r_a;        // multiplicand, pre-shifted by 2i each step
    logic [N:0]     r_bx;       // {B, 1'b0}: bit 0 supplies B[-1] = 0
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_product;
    logic           r_done;

    logic [0:0]     w_state_nxt;
    logic [2*N-1:0] w_a_nxt;
    logic [N:0]     w_bx_nxt;
    logic [2*N-1:0] w_acc_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [2*N-1:0] w_product_nxt;
    logic           w_done_nxt;

    // ------------------------------------------------------------------------
    // Booth recoding of the current triplet and partial product formation.
    // The multiplier is shifted right by two each step, so the active triplet
    // always sits in r_bx[2:0]; the multiplicand is shifted left by two in
    // step, so it already carries the 2i weight.
    // ------------------------------------------------------------------------
    logic [2:0]     w_trip;
    logic           w_neg;
    logic           w_one;
    logic           w_two;
    logic [2*N-1:0] w_mag;
    logic [2*N-1:0] w_pp;
    logic [2*N-1:0] w_sum;

    always_comb begin
        w_trip = r_bx[2:0];
        w_neg  = w_trip[2];
        w_one  = w_trip[1] ^ w_trip[0];
        w_two  = (w_trip == 3'b011) || (w_trip == 3'b100);

        if (w_one) begin
            w_mag = r_a;
        end else if (w_two) begin
            w_mag = {r_a[2*N-2:0], 1'b0};
        end else begin
            w_mag = '0;
        end

        // For 111 the magnitude is zero and ~0 + 1 wraps back to zero.
        w_pp  = w_neg ? (~w_mag + c_one) : w_mag;
        w_sum = r_acc + w_pp;
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_bx_nxt      = r_bx;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_product_nxt = r_product;
        w_done_nxt    = 1'b0;

        case (r_state)
            c_idle: begin
                if (start) begin
                    w_state_nxt = c_run;
                    w_a_nxt     = {{N{a[N-1]}}, a};
                    w_bx_nxt    = {b, 1'b0};
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            c_run: begin
                w_acc_nxt = w_sum;
                w_a_nxt   = {r_a[2*N-3:0], 2'b00};
                w_bx_nxt  = {2'b00, r_bx[N:2]};
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt   = c_idle;
                    w_product_nxt = w_sum;
                    w_done_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_a       <= '0;
            r_bx      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_bx      <= w_bx_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_product <= w_product_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy    = (r_state == c_run);
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire
